// File: rtl/sipo_pkg.sv
// Shared types and sizing helpers for the
// serial-in/parallel-out word assembler.
package sipo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// Shift register for the deserializer; restarts
// from a single bit on sync or shifts on enable.
module sipo_shift_reg
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             din,
  input  logic             load,
  input  logic             shift,
  output logic [WIDTH-1:0] nxt
);

  logic [WIDTH-1:0] sr;

  always_comb begin
    nxt = sr;
    if (load) begin
      if (MSB_FIRST)
        nxt = {{(WIDTH-1){1'b0}}, din};
      else
        nxt = {din, {(WIDTH-1){1'b0}}};
    end else if (shift) begin
      if (MSB_FIRST)
        nxt = {sr[WIDTH-2:0], din};
      else
        nxt = {din, sr[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n)
      sr <= '0;
    else
      sr <= nxt;
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Frames a sampled bit stream into words and
// offers them on a valid/ready port with overrun flag.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_en,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  input  logic             clr_ovr
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE =
    CNT_W'(1);

  state_t           state, state_d;
  logic [CNT_W-1:0] bit_cnt, cnt_d;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] dout_d;
  logic             valid_d, ovr_d;
  logic             sync, shift_en, complete;

  sipo_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_sr (
    .clk1  (clk1),
    .rst_n (rst_n),
    .din   (din),
    .load  (sync),
    .shift (shift_en),
    .nxt   (word)
  );

  always_comb begin
    sync     = din_en & frame_sync;
    shift_en = 1'b0;
    state_d  = state;
    cnt_d    = bit_cnt;
    unique case (state)
      IDLE: begin
        if (sync) begin
          state_d = SHIFT;
          cnt_d   = ONE;
        end
      end
      SHIFT: begin
        if (sync) begin
          cnt_d = ONE;
        end else if (din_en) begin
          shift_en = 1'b1;
          cnt_d    = (bit_cnt == LAST) ?
                     '0 : bit_cnt + ONE;
        end
      end
      default: state_d = IDLE;
    endcase
    complete = shift_en & (bit_cnt == LAST);
  end

  // A word only lands if the output slot is free
  // or being emptied on this very edge.
  always_comb begin
    dout_d  = dout;
    valid_d = dout_valid;
    ovr_d   = overrun & ~clr_ovr;
    if (complete) begin
      if (!dout_valid || dout_ready) begin
        dout_d  = word;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (dout_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_d;
      bit_cnt    <= cnt_d;
      dout       <= dout_d;
      dout_valid <= valid_d;
      overrun    <= ovr_d;
    end
  end

endmodule
